// File: rtl/jesd_rx_pack32.sv
`default_nettype none
// ============================================================================
// Module   : jesd_rx_pack32
// Brief    : Packs 16-bit I/Q sample pairs into 32-bit words behind a FWFT FIFO.
//            Optional dropped-word counter enabled by JESD_PACK_OVF_CNT_EN.
// Revision : 1.0
// ============================================================================
module jesd_rx_pack32 #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                            rx_link_clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            din_valid,
    input  logic [DATA_IN_WIDTH-1:0]        din_real,
    input  logic [DATA_IN_WIDTH-1:0]        din_imag,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [DATA_OUT_WIDTH-1:0]       dout_real,
    output logic [DATA_OUT_WIDTH-1:0]       dout_imag,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [15:0]                     ovf_count
);

    localparam int                  c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int                  c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0]  c_depth = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0]  c_one   = c_lvl_w'(1);

    logic                       r_phase;
    logic [DATA_IN_WIDTH-1:0]   r_hold_real;
    logic [DATA_IN_WIDTH-1:0]   r_hold_imag;
    logic                       r_push_vld;
    logic [DATA_OUT_WIDTH-1:0]  r_push_real;
    logic [DATA_OUT_WIDTH-1:0]  r_push_imag;
    logic [c_ptr_w-1:0]         r_wr_ptr;
    logic [c_ptr_w-1:0]         r_rd_ptr;
    logic [c_lvl_w-1:0]         r_level;
    logic                       r_dout_valid;
    logic [DATA_OUT_WIDTH-1:0]  r_dout_real;
    logic [DATA_OUT_WIDTH-1:0]  r_dout_imag;
    logic                       r_overflow;
    logic [DATA_OUT_WIDTH-1:0]  r_mem_real [FIFO_DEPTH];
    logic [DATA_OUT_WIDTH-1:0]  r_mem_imag [FIFO_DEPTH];

    logic w_pop;
    logic w_push_ok;
    logic w_drop;
    logic w_mem_empty;
    logic w_load_mem;
    logic w_load_push;
    logic w_mem_wr;

    // The output register counts as one FIFO slot; memory holds level-1 words.
    assign w_pop       = r_dout_valid & dout_ready;
    assign w_push_ok   = r_push_vld & ((r_level < c_depth) | w_pop);
    assign w_drop      = r_push_vld & ~w_push_ok;
    assign w_mem_empty = (r_level <= c_one);
    assign w_load_mem  = w_pop & ~w_mem_empty;
    assign w_load_push = w_push_ok & (~r_dout_valid | (w_pop & w_mem_empty));
    assign w_mem_wr    = w_push_ok & ~w_load_push;

    always_ff @(posedge rx_link_clk or posedge rst) begin
        if (rst) begin
            r_phase      <= 1'b0;
            r_hold_real  <= '0;
            r_hold_imag  <= '0;
            r_push_vld   <= 1'b0;
            r_push_real  <= '0;
            r_push_imag  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_dout_valid <= 1'b0;
            r_dout_real  <= '0;
            r_dout_imag  <= '0;
            r_overflow   <= 1'b0;
        end else if (!enable) begin
            r_phase      <= 1'b0;
            r_hold_real  <= '0;
            r_hold_imag  <= '0;
            r_push_vld   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (din_valid) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hold_real <= din_real;
                    r_hold_imag <= din_imag;
                end else begin
                    r_push_real <= {din_real, r_hold_real};
                    r_push_imag <= {din_imag, r_hold_imag};
                end
            end
            r_push_vld <= din_valid & r_phase;

            if (w_mem_wr)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_load_mem)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);

            if (w_push_ok && !w_pop)
                r_level <= r_level + c_one;
            else if (!w_push_ok && w_pop)
                r_level <= r_level - c_one;

            if (w_load_mem) begin
                r_dout_real  <= r_mem_real[r_rd_ptr];
                r_dout_imag  <= r_mem_imag[r_rd_ptr];
                r_dout_valid <= 1'b1;
            end else if (w_load_push) begin
                r_dout_real  <= r_push_real;
                r_dout_imag  <= r_push_imag;
                r_dout_valid <= 1'b1;
            end else if (w_pop) begin
                r_dout_valid <= 1'b0;
            end

            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge rx_link_clk) begin
        if (enable && w_mem_wr) begin
            r_mem_real[r_wr_ptr] <= r_push_real;
            r_mem_imag[r_wr_ptr] <= r_push_imag;
        end
    end

`ifdef JESD_PACK_OVF_CNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge rx_link_clk or posedge rst) begin
        if (rst)
            r_ovf_count <= '0;
        else if (!enable)
            r_ovf_count <= '0;
        else if (w_drop && (r_ovf_count != 16'hFFFF))
            r_ovf_count <= r_ovf_count + 16'd1;
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = 16'h0000;
`endif

    assign dout_valid = r_dout_valid;
    assign dout_real  = r_dout_real;
    assign dout_imag  = r_dout_imag;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_jesd_rx_pack32.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd_rx_pack32
// Brief    : Self-checking bench for jesd_rx_pack32 (queue model + literals).
// Revision : 1.0
// ============================================================================
module tb_jesd_rx_pack32;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        din_valid;
    logic [15:0] din_real;
    logic [15:0] din_imag;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_real;
    logic [31:0] dout_imag;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] ovf_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jesd_rx_pack32 #(
        .DATA_IN_WIDTH (16),
        .DATA_OUT_WIDTH(32),
        .FIFO_DEPTH    (DEPTH)
    ) u_dut (
        .rx_link_clk(clk),
        .rst        (rst),
        .enable     (enable),
        .din_valid  (din_valid),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_real  (dout_real),
        .dout_imag  (dout_imag),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_count  (ovf_count)
    );

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a word queue plus a one-cycle staging slot for completed pairs.
    logic [31:0] q_re[$];
    logic [31:0] q_im[$];
    bit          m_phase;
    logic [15:0] m_hr, m_hi;
    bit          m_pend;
    logic [31:0] m_pr, m_pi;
    bit          m_ovf;
    int          m_cnt;
    bit          m_pop;
    bit          m_room;

    always @(posedge clk or posedge rst) begin
        if (rst || !enable) begin
            q_re.delete();
            q_im.delete();
            m_phase = 0;
            m_pend  = 0;
            m_ovf   = 0;
            m_cnt   = 0;
        end else begin
            m_pop  = (q_re.size() > 0) && dout_ready;
            m_room = q_re.size() < DEPTH;
            if (m_pop) begin
                void'(q_re.pop_front());
                void'(q_im.pop_front());
            end
            if (m_pend) begin
                if (m_room || m_pop) begin
                    q_re.push_back(m_pr);
                    q_im.push_back(m_pi);
                end else begin
                    m_ovf = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            m_pend = 0;
            if (din_valid) begin
                if (!m_phase) begin
                    m_hr = din_real;
                    m_hi = din_imag;
                end else begin
                    m_pend = 1;
                    m_pr   = {din_real, m_hr};
                    m_pi   = {din_imag, m_hi};
                end
                m_phase = !m_phase;
            end
        end
    end

    function automatic int exp_cnt();
`ifdef JESD_PACK_OVF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Record every word the consumer takes, for the literal order checks.
    logic [31:0] out_re[$];
    logic [31:0] out_im[$];
    int          valid_cycles = 0;

    always @(posedge clk) begin
        if (!rst && enable && dout_valid) begin
            valid_cycles++;
            if (dout_ready) begin
                out_re.push_back(dout_real);
                out_im.push_back(dout_imag);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", dout_valid, 0);
            chk("rst_level", fifo_level, 0);
            chk("rst_real",  dout_real, 0);
        end else begin
            chk("valid", dout_valid, q_re.size() > 0);
            chk("level", fifo_level, q_re.size());
            if (q_re.size() > 0) begin
                chk("dout_real", dout_real, q_re[0]);
                chk("dout_imag", dout_imag, q_im[0]);
            end
            chk("overflow",  overflow,  m_ovf);
            chk("ovf_count", ovf_count, exp_cnt());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [15:0] re, input logic [15:0] im);
        din_valid = v;
        din_real  = re;
        din_imag  = im;
        tick();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    int n0;
    int vc0;

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        din_valid  = 1'b0;
        din_real   = '0;
        din_imag   = '0;
        dout_ready = 1'b1;
        idle(3);
        chk("reset_valid", dout_valid, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_ovf",   overflow,   0);
        rst    = 1'b0;
        enable = 1'b1;
        idle(2);

        // Single pair, latency and one-cycle valid
        n0  = out_re.size();
        vc0 = valid_cycles;
        send(1'b1, 16'h0001, 16'h1001);
        send(1'b1, 16'h0002, 16'h1002);
        din_valid = 1'b0;
        chk("lat_c1_valid", dout_valid, 0);
        tick();
        chk("lat_c2_valid", dout_valid, 1);
        chk("lat_c2_real",  dout_real, 32'h0002_0001);
        chk("lat_c2_imag",  dout_imag, 32'h1002_1001);
        idle(4);
        chk("t2_words",        out_re.size() - n0, 1);
        chk("t2_valid_cycles", valid_cycles - vc0, 1);

        // Gapped input keeps pairing
        n0 = out_re.size();
        send(1'b1, 16'h000A, 16'h010A); idle(1);
        send(1'b1, 16'h000B, 16'h010B); idle(1);
        send(1'b1, 16'h000C, 16'h010C); idle(1);
        send(1'b1, 16'h000D, 16'h010D); idle(4);
        chk("gap_words", out_re.size() - n0, 2);
        if (out_re.size() - n0 == 2) begin
            chk("gap_w0", out_re[n0],     32'h000B_000A);
            chk("gap_w1", out_re[n0 + 1], 32'h000D_000C);
            chk("gap_i1", out_im[n0 + 1], 32'h010D_010C);
        end

        // Partial pair discarded by enable=0
        n0 = out_re.size();
        send(1'b1, 16'h1111, 16'h5111);
        enable = 1'b0;
        tick();
        chk("dis_level", fifo_level, 0);
        chk("dis_valid", dout_valid, 0);
        enable = 1'b1;
        send(1'b1, 16'h2222, 16'h6222);
        send(1'b1, 16'h3333, 16'h7333);
        idle(4);
        chk("flush_words", out_re.size() - n0, 1);
        if (out_re.size() - n0 == 1)
            chk("flush_w0", out_re[n0], 32'h3333_2222);

        // Overflow: 17 pairs into a stalled 16-deep FIFO
        dout_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            send(1'b1, 16'(2 * k),     16'(16'h8000 + 2 * k));
            send(1'b1, 16'(2 * k + 1), 16'(16'h8000 + 2 * k + 1));
        end
        idle(3);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag",  overflow,   1);
`ifdef JESD_PACK_OVF_CNT_EN
        chk("ovf_cnt", ovf_count, 1);
`else
        chk("ovf_cnt", ovf_count, 0);
`endif
        n0 = out_re.size();
        dout_ready = 1'b1;
        idle(20);
        chk("drain_words", out_re.size() - n0, 16);
        for (int k = 0; k < 16; k++)
            if (n0 + k < out_re.size())
                chk("drain_order", out_re[n0 + k], {16'(2 * k + 1), 16'(2 * k)});
        chk("drain_sticky", overflow, 1);

        enable = 1'b0;
        tick();
        chk("ovf_clear", overflow, 0);
        enable = 1'b1;

        // Full FIFO: a push meeting a pop is accepted
        dout_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 16'(k), 16'h0);
            send(1'b1, 16'(k + 16'h40), 16'h0);
        end
        idle(2);
        chk("full_level", fifo_level, 16);
        n0 = out_re.size();
        send(1'b1, 16'hAAAA, 16'h5555);
        send(1'b1, 16'hBBBB, 16'h6666);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        tick();
        chk("pp_level", fifo_level, 16);
        chk("pp_ovf",   overflow,   0);
        idle(20);
        chk("pp_words", out_re.size() - n0, 17);
        if (out_re.size() - n0 == 17) begin
            chk("pp_last", out_re[n0 + 16], 32'hBBBB_AAAA);
            chk("pp_first", out_re[n0], 32'h0040_0000);
        end

        // Asynchronous reset mid-stream
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 16'(k + 1), 16'(k + 2));
            send(1'b1, 16'(k + 3), 16'(k + 4));
        end
        idle(2);
        chk("pre_rst_level", fifo_level, 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_real",  dout_real,  0);
        chk("arst_imag",  dout_imag,  0);
        chk("arst_ovf",   overflow,   0);
        chk("arst_cnt",   ovf_count,  0);
        idle(2);
        rst        = 1'b0;
        dout_ready = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
